blade_ignition_ctrl: RTL and testbench
======================================

# blade_ignition_ctrl

Sequencer for the lightsaber blade-length datapath. Accepts a requested length in split meters/centimetres form over a valid/ready handshake. Validates and saturates the request, then ramps the live blade length toward it on ignite and back to zero on retract. Sits between the user command source and the blade/hilt length registers; its current-length outputs drive the display and emitter stages.

## Interface
- MAX_CM, default 100: maximum blade length in cm (1.00 m).
- STEP_CM, default 5: cm added or removed per ramp step.
- TICK_DIV, default 4: clock cycles per ramp step; must be ≥1.
- HILT_CM, default 10: hilt length reported in double-hilt configuration.

Ports:
- clk, in, 1: sole clock, rising edge.
- rst, in, 1: asynchronous, active-low reset.
- ignite, in, 1: one-cycle command to extend the blade to the target.
- retract, in, 1: one-cycle command to retract the blade to zero.
- load_valid, in, 1: length request valid.
- load_ready, out, 1: request accepted when high with load_valid.
- lengthL, in, 16: requested metres, signed.
- lengthR, in, 16: requested cm, signed.
- bladeConfig, in, 2: 0 none, 1 single, 2 double, 3 double-hilt; sampled with the request.
- curL, out, 16: live length, metres part.
- curR, out, 16: live length, cm part.
- curH, out, 16: hilt length in cm.
- state, out, 2: 0 OFF, 1 EXTEND, 2 ON, 3 RETRACT.
- done, out, 1: one-cycle pulse on ramp completion.
- fault, out, 1: one-cycle pulse on a rejected request or command.

## Operation
**Internal registers**
- cur_cm: 8 bits, 0..MAX_CM.
- tgt_cm: 8 bits.
- cfg: 2 bits.
- tick counter.
- state.

**Load request**
- load_ready = (state==OFF or state==ON). This is combinational from state only.
- On acceptance, compute req = lengthL*100 + lengthR using 32-bit signed intermediate arithmetic.
- Reject and pulse fault the next cycle, leaving tgt_cm and cfg unchanged, if any of these hold: lengthL[15] or lengthR[15] is set; req == 0; bladeConfig == 0.
- Otherwise tgt_cm = min(req, MAX_CM) and cfg = bladeConfig. Oversize requests saturate silently with no fault.
- An accepted load in ON:
  - If tgt_cm > cur_cm, go to EXTEND.
  - If tgt_cm < cur_cm, go to RETRACT toward tgt_cm.
  - If equal, stay in ON.
- An accepted load in OFF only updates the registers; there is no state change.

**FSM**
- OFF: on ignite with tgt_cm ≠ 0 and cfg ≠ 0, go to EXTEND. On ignite otherwise, pulse fault and stay in OFF.
- EXTEND: each step, cur_cm = min(cur_cm+STEP_CM, goal). When cur_cm reaches goal, go to ON and pulse done.
- ON: hold. Retract goes to RETRACT with goal = 0.
- RETRACT: each step, cur_cm = max(cur_cm−STEP_CM, goal). When it reaches goal, go to OFF (goal 0) or ON (goal > 0), and pulse done.
- The goal is tgt_cm during EXTEND and load-initiated RETRACT, and 0 during command-initiated RETRACT.
- retract in EXTEND or ON redirects immediately to RETRACT with goal 0. retract in OFF or RETRACT is ignored.
- ignite outside OFF is ignored with no fault.

**Outputs**
- curL = (cur_cm==100) ? 1 : 0.
- curR = (cur_cm==100) ? 0 : cur_cm.
- Both are zero-extended to 16 bits.
- curH = HILT_CM when cfg==3 and state≠OFF; otherwise 0.

## Timing
- Reset (rst low), asynchronous: state=OFF, cur_cm=0, tgt_cm=0, cfg=0, tick=0, done=0, fault=0. Therefore curL=curR=curH=0 and load_ready=1.
- Reset asserted mid-ramp forces OFF immediately. There is no retract sequence.
- The state transition on a command happens at the first clock edge after it is sampled. The tick counter clears on entry to EXTEND or RETRACT, including a redirect.
- The first step is applied TICK_DIV cycles after entry, and subsequent steps every TICK_DIV cycles.
- Full extension from 0 to 100 with default parameters takes 20 steps, i.e. 80 cycles after entering EXTEND. done is asserted in the cycle state first reads ON.
- A final partial step clamps to goal, so cur_cm never overshoots.
- Simultaneous events in one cycle:
  - retract beats ignite.
  - retract beats a load-induced transition. The load is still accepted and its registers are updated.
  - In OFF, an accepted load and ignite together: ignite uses the old tgt_cm/cfg.
- done and fault are registered, one cycle wide, and never asserted together.

## Test plan
- Reset, then load 0/75 config 1, then ignite → EXTEND; cur steps 5,10,…,75 every 4 cycles; ON after 60 cycles; done pulses once; curL=0, curR=75, curH=0.
- Load 1/20 config 3, then ignite → target saturates to 100 with no fault; final curL=1, curR=0, curH=10. Then retract → ramps to 0, state OFF, done pulse, curH=0.
- Loads with −1/0, 0/−1, 0/0, and config 0 → fault pulse each time; tgt unchanged. Ignite with tgt=0 → fault, stays OFF.
- In ON at 50, load 0/23 → RETRACT; cur 45,40,…,25,23; ON with done. Then load 0/23 again → no state change.
- Mid-EXTEND at cur=30, assert ignite and retract in the same cycle → RETRACT to 0. A later ignite in RETRACT is ignored.
- Assert rst low mid-EXTEND at cur=40 → all outputs 0 immediately, state OFF, load_ready=1; after release, ignite faults because tgt was cleared.

Source files
------------

// File: rtl/blade_ignition_ctrl.sv
// rtl/blade_ignition_ctrl.sv - blade length sequencer: validated length load, ignite/retract ramp FSM
module blade_ignition_ctrl #(
  parameter int MAX_CM   = 100,
  parameter int STEP_CM  = 5,
  parameter int TICK_DIV = 4,
  parameter int HILT_CM  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ignite,
  input  logic        retract,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] lengthL,
  input  logic [15:0] lengthR,
  input  logic [1:0]  bladeConfig,
  output logic [15:0] curL,
  output logic [15:0] curR,
  output logic [15:0] curH,
  output logic [1:0]  state,
  output logic        done,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_OFF     = 2'd0,
    S_EXTEND  = 2'd1,
    S_ON      = 2'd2,
    S_RETRACT = 2'd3
  } state_t;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [7:0]  MAX_CM8   = 8'(MAX_CM);
  localparam logic [7:0]  STEP8     = 8'(STEP_CM);

  state_t      st;
  logic [7:0]  cur_cm;
  logic [7:0]  tgt_cm;
  logic [7:0]  goal_cm;
  logic [1:0]  cfg;
  logic [15:0] tick;

  logic               load_acc;
  logic               req_bad;
  logic signed [31:0] req;
  logic [7:0]         req_cm;
  logic               step_now;
  logic [8:0]         up_sum;
  logic [8:0]         dn_lim;

  // Request decode: split metres/cm folded into one signed cm value, then saturated
  assign load_ready = (st == S_OFF) || (st == S_ON);
  assign load_acc   = load_valid && load_ready;
  assign req        = $signed({{16{lengthL[15]}}, lengthL}) * 32'sd100
                    + $signed({{16{lengthR[15]}}, lengthR});
  assign req_bad    = lengthL[15] | lengthR[15] | (req == 32'sd0) | (bladeConfig == 2'd0);
  assign req_cm     = (req > $signed(32'(MAX_CM))) ? MAX_CM8 : req[7:0];

  // Ramp arithmetic is one bit wider so a step past the goal is detected before clamping
  assign step_now = (tick == TICK_LAST);
  assign up_sum   = {1'b0, cur_cm} + {1'b0, STEP8};
  assign dn_lim   = {1'b0, goal_cm} + {1'b0, STEP8};

  // Output mapping: 100 cm is reported as 1 m 0 cm, anything shorter as 0 m n cm
  assign state = st;
  assign curL  = (cur_cm == 8'd100) ? 16'd1 : 16'd0;
  assign curR  = (cur_cm == 8'd100) ? 16'd0 : {8'd0, cur_cm};
  assign curH  = ((cfg == 2'd3) && (st != S_OFF)) ? 16'(HILT_CM) : 16'd0;

  // Sequencer: load handling, command decode and tick-paced ramp with registered pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= S_OFF;
      cur_cm  <= 8'd0;
      tgt_cm  <= 8'd0;
      goal_cm <= 8'd0;
      cfg     <= 2'd0;
      tick    <= 16'd0;
      done    <= 1'b0;
      fault   <= 1'b0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (st)
        S_OFF: begin
          if (load_acc) begin
            if (req_bad) begin
              fault <= 1'b1;
            end else begin
              tgt_cm <= req_cm;
              cfg    <= bladeConfig;
            end
          end
          // ignite looks at the registers as they were before any same-cycle load
          if (ignite) begin
            if ((tgt_cm != 8'd0) && (cfg != 2'd0)) begin
              st      <= S_EXTEND;
              goal_cm <= tgt_cm;
              tick    <= 16'd0;
            end else begin
              fault <= 1'b1;
            end
          end
        end
        S_ON: begin
          if (load_acc) begin
            if (req_bad) begin
              fault <= 1'b1;
            end else begin
              tgt_cm <= req_cm;
              cfg    <= bladeConfig;
              if (!retract) begin
                if (req_cm > cur_cm) begin
                  st      <= S_EXTEND;
                  goal_cm <= req_cm;
                  tick    <= 16'd0;
                end else if (req_cm < cur_cm) begin
                  st      <= S_RETRACT;
                  goal_cm <= req_cm;
                  tick    <= 16'd0;
                end
              end
            end
          end
          if (retract) begin
            st      <= S_RETRACT;
            goal_cm <= 8'd0;
            tick    <= 16'd0;
          end
        end
        S_EXTEND: begin
          if (retract) begin
            st      <= S_RETRACT;
            goal_cm <= 8'd0;
            tick    <= 16'd0;
          end else if (step_now) begin
            tick <= 16'd0;
            if (up_sum >= {1'b0, goal_cm}) begin
              cur_cm <= goal_cm;
              st     <= S_ON;
              done   <= 1'b1;
            end else begin
              cur_cm <= up_sum[7:0];
            end
          end else begin
            tick <= tick + 16'd1;
          end
        end
        S_RETRACT: begin
          if (step_now) begin
            tick <= 16'd0;
            if ({1'b0, cur_cm} <= dn_lim) begin
              cur_cm <= goal_cm;
              st     <= (goal_cm == 8'd0) ? S_OFF : S_ON;
              done   <= 1'b1;
            end else begin
              cur_cm <= cur_cm - STEP8;
            end
          end else begin
            tick <= tick + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blade_ignition_ctrl.sv
// tb/tb_blade_ignition_ctrl.sv - directed self-checking bench for blade_ignition_ctrl
module tb_blade_ignition_ctrl;

  logic        clk;
  logic        rst;
  logic        ignite;
  logic        retract;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] lengthL;
  logic [15:0] lengthR;
  logic [1:0]  bladeConfig;
  logic [15:0] curL;
  logic [15:0] curR;
  logic [15:0] curH;
  logic [1:0]  state;
  logic        done;
  logic        fault;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;
  int dcnt     = 0;
  int fcnt     = 0;

  logic [15:0] bad_l [4];
  logic [15:0] bad_r [4];
  logic [1:0]  bad_c [4];

  blade_ignition_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .ignite      (ignite),
    .retract     (retract),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .lengthL     (lengthL),
    .lengthR     (lengthR),
    .bladeConfig (bladeConfig),
    .curL        (curL),
    .curR        (curR),
    .curH        (curH),
    .state       (state),
    .done        (done),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // advance n cycles, counting done and fault pulses seen on the way
  task automatic run(input int n);
    dcnt = 0;
    fcnt = 0;
    repeat (n) begin
      cyc(1);
      if (done)  dcnt++;
      if (fault) fcnt++;
    end
  endtask

  task automatic load(input logic [15:0] l, input logic [15:0] r, input logic [1:0] c);
    load_valid  = 1'b1;
    lengthL     = l;
    lengthR     = r;
    bladeConfig = c;
    cyc(1);
    load_valid  = 1'b0;
  endtask

  task automatic pulse_ignite();
    ignite = 1'b1;
    cyc(1);
    ignite = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ignite = 1'b0; retract = 1'b0; load_valid = 1'b0;
    lengthL = 16'd0; lengthR = 16'd0; bladeConfig = 2'd0;
    bad_l[0] = 16'hFFFF; bad_r[0] = 16'd0;    bad_c[0] = 2'd3;
    bad_l[1] = 16'd0;    bad_r[1] = 16'hFFFF; bad_c[1] = 2'd3;
    bad_l[2] = 16'd0;    bad_r[2] = 16'd0;    bad_c[2] = 2'd3;
    bad_l[3] = 16'd0;    bad_r[3] = 16'd30;   bad_c[3] = 2'd0;

    // reset state
    cyc(3);
    chk("rst_state", 32'(state), 0);
    chk("rst_curl", 32'(curL), 0);
    chk("rst_curr", 32'(curR), 0);
    chk("rst_curh", 32'(curH), 0);
    chk("rst_ready", 32'(load_ready), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_fault", 32'(fault), 0);
    rst = 1'b1;
    cyc(1);

    // load 0/75 single, ignite, ramp in steps of 5 every 4 cycles
    load(16'd0, 16'd75, 2'd1);
    chk("t1_load_fault", 32'(fault), 0);
    chk("t1_load_state", 32'(state), 0);
    pulse_ignite();
    chk("t1_ign_state", 32'(state), 1);
    chk("t1_ign_cur", 32'(curR), 0);
    cyc(3);
    chk("t1_pre_step", 32'(curR), 0);
    cyc(1);
    chk("t1_step1", 32'(curR), 5);
    run(56);
    chk("t1_cur", 32'(curR), 75);
    chk("t1_state_on", 32'(state), 2);
    chk("t1_done", 32'(done), 1);
    chk("t1_done_cnt", 32'(dcnt), 1);
    chk("t1_curl", 32'(curL), 0);
    chk("t1_curh", 32'(curH), 0);
    cyc(1);
    chk("t1_done_clr", 32'(done), 0);

    // load 1/20 double-hilt in ON: saturates to 100, extends, no fault
    load(16'd1, 16'd20, 2'd3);
    chk("t2_state_ext", 32'(state), 1);
    chk("t2_fault", 32'(fault), 0);
    chk("t2_curh_on", 32'(curH), 10);
    run(20);
    chk("t2_state_on", 32'(state), 2);
    chk("t2_curl", 32'(curL), 1);
    chk("t2_curr", 32'(curR), 0);
    chk("t2_curh", 32'(curH), 10);
    chk("t2_done_cnt", 32'(dcnt), 1);
    chk("t2_fault_cnt", 32'(fcnt), 0);
    retract = 1'b1;
    cyc(1);
    retract = 1'b0;
    chk("t2_ret_state", 32'(state), 3);
    run(40);
    chk("t2_ret_mid", 32'(curR), 50);
    run(40);
    chk("t2_off", 32'(state), 0);
    chk("t2_off_cur", 32'(curR), 0);
    chk("t2_off_done", 32'(done), 1);
    chk("t2_off_curh", 32'(curH), 0);

    // valid load, then rejected loads which must leave tgt/cfg untouched
    load(16'd0, 16'd50, 2'd1);
    chk("t3_good_fault", 32'(fault), 0);
    for (int i = 0; i < 4; i++) begin
      load(bad_l[i], bad_r[i], bad_c[i]);
      chk($sformatf("t3_bad%0d_fault", i), 32'(fault), 1);
      chk($sformatf("t3_bad%0d_state", i), 32'(state), 0);
      cyc(1);
      chk($sformatf("t3_bad%0d_clr", i), 32'(fault), 0);
    end
    pulse_ignite();
    chk("t3_ign_state", 32'(state), 1);
    chk("t3_ign_curh", 32'(curH), 0);
    run(40);
    chk("t3_on", 32'(state), 2);
    chk("t3_cur", 32'(curR), 50);
    chk("t3_done", 32'(done), 1);

    // shrink from 50 to 23 by load: final partial step clamps
    load(16'd0, 16'd23, 2'd1);
    chk("t4_state_ret", 32'(state), 3);
    run(20);
    chk("t4_cur25", 32'(curR), 25);
    chk("t4_not_on", 32'(state), 3);
    run(4);
    chk("t4_cur23", 32'(curR), 23);
    chk("t4_on", 32'(state), 2);
    chk("t4_done", 32'(done), 1);
    load(16'd0, 16'd23, 2'd1);
    chk("t4_same_state", 32'(state), 2);
    chk("t4_same_fault", 32'(fault), 0);
    chk("t4_same_done", 32'(done), 0);

    // retract to off, then ignite+retract together mid-extend
    retract = 1'b1;
    cyc(1);
    retract = 1'b0;
    run(20);
    chk("t5_off", 32'(state), 0);
    chk("t5_off_done", 32'(dcnt), 1);
    load(16'd1, 16'd0, 2'd3);
    pulse_ignite();
    chk("t5_ext", 32'(state), 1);
    run(24);
    chk("t5_cur30", 32'(curR), 30);
    ignite = 1'b1;
    retract = 1'b1;
    cyc(1);
    retract = 1'b0;
    chk("t5_redirect", 32'(state), 3);
    chk("t5_redirect_cur", 32'(curR), 30);
    cyc(1);
    ignite = 1'b0;
    chk("t5_ign_ignored", 32'(state), 3);
    chk("t5_ign_nofault", 32'(fault), 0);
    run(23);
    chk("t5_off2", 32'(state), 0);
    chk("t5_off2_cur", 32'(curR), 0);
    chk("t5_off2_done", 32'(done), 1);
    chk("t5_fault_cnt", 32'(fcnt), 0);

    // asynchronous reset mid-extend at 40
    pulse_ignite();
    run(32);
    chk("t6_cur40", 32'(curR), 40);
    chk("t6_curh", 32'(curH), 10);
    rst = 1'b0;
    #2;
    chk("t6_rst_state", 32'(state), 0);
    chk("t6_rst_curr", 32'(curR), 0);
    chk("t6_rst_curl", 32'(curL), 0);
    chk("t6_rst_curh", 32'(curH), 0);
    chk("t6_rst_ready", 32'(load_ready), 1);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    pulse_ignite();
    chk("t6_ign_fault", 32'(fault), 1);
    chk("t6_ign_state", 32'(state), 0);

    // load and ignite together in OFF: ignite sees the cleared target
    load_valid = 1'b1; lengthL = 16'd0; lengthR = 16'd60; bladeConfig = 2'd1;
    ignite = 1'b1;
    cyc(1);
    load_valid = 1'b0;
    ignite = 1'b0;
    chk("t7_fault", 32'(fault), 1);
    chk("t7_state", 32'(state), 0);
    pulse_ignite();
    chk("t7_ign_state", 32'(state), 1);
    chk("t7_ign_fault", 32'(fault), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
